// File: rtl/phase_sequencer.sv
// Eight-phase fetch/execute sequencer: run/step/halt control, memory stall handling, retired-instruction count.
// Latency: outputs registered, phase advances one per clock; stalls hold phase while rd|wr waits on mem_ready.
module phase_sequencer #(
    parameter int WAIT_LIMIT = 15,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             halt_req,
    input  logic             rd,
    input  logic             wr,
    input  logic             mem_ready,
    output logic [2:0]       phase,
    output logic             running,
    output logic             halted,
    output logic             timeout_err,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RUN    = 3'd1,
        S_STALL  = 3'd2,
        S_HALTED = 3'd3,
        S_ERROR  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic               step_flag_q, step_flag_d;
    logic [7:0]         wait_q, wait_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               running_q, running_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic               adv;
    logic               do_adv;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_flag_d = step_flag_q;
        wait_d      = wait_q;
        count_d     = count_q;
        adv         = !(rd | wr) | mem_ready;
        do_adv      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d = S_RUN;
                end else if (step) begin
                    state_d     = S_RUN;
                    step_flag_d = 1'b1;
                end
            end
            S_RUN: begin
                if (adv) begin
                    do_adv = 1'b1;
                end else begin
                    state_d = S_STALL;
                    wait_d  = wait_q + 8'd1;
                end
            end
            S_STALL: begin
                if (mem_ready) begin
                    do_adv = 1'b1;
                end else if (int'(wait_q) + 1 >= WAIT_LIMIT) begin
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            S_HALTED, S_ERROR: ;
            default: state_d = S_IDLE;
        endcase

        // A stalled access resolving at phase 4 or 7 still takes the boundary action on that edge.
        if (do_adv) begin
            state_d = S_RUN;
            wait_d  = 8'd0;
            phase_d = phase_q + 3'd1;
            if (phase_q == 3'd4 && halt_req) begin
                phase_d     = 3'd0;
                count_d     = count_q + 1'b1;
                state_d     = S_HALTED;
                step_flag_d = 1'b0;
            end else if (phase_q == 3'd7) begin
                count_d = count_q + 1'b1;
                if (step_flag_q || !run) begin
                    state_d     = S_IDLE;
                    step_flag_d = 1'b0;
                end
            end
        end

        running_d = (state_d == S_RUN) || (state_d == S_STALL);
        halted_d  = (state_d == S_HALTED);
        timeout_d = (state_d == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            phase_q     <= 3'd0;
            step_flag_q <= 1'b0;
            wait_q      <= 8'd0;
            count_q     <= '0;
            running_q   <= 1'b0;
            halted_q    <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_flag_q <= step_flag_d;
            wait_q      <= wait_d;
            count_q     <= count_d;
            running_q   <= running_d;
            halted_q    <= halted_d;
            timeout_q   <= timeout_d;
        end
    end

    assign phase       = phase_q;
    assign running     = running_q;
    assign halted      = halted_q;
    assign timeout_err = timeout_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed bench for phase_sequencer: run, stall, timeout, halt, step, run-drop and counter wrap.
module tb_phase_sequencer;

    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst, run, step, halt_req, rd, wr, mem_ready;
    logic [2:0]    phase;
    logic          running, halted, timeout_err;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;

    phase_sequencer #(.WAIT_LIMIT(15), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
        .rd(rd), .wr(wr), .mem_ready(mem_ready), .phase(phase), .running(running),
        .halted(halted), .timeout_err(timeout_err), .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; run = 1'b0; step = 1'b0; halt_req = 1'b0;
        rd = 1'b0; wr = 1'b0; mem_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (phase !== 3'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
        checks++; if ({running, halted, timeout_err} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {running, halted, timeout_err}); end
        checks++; if (instr_count !== 8'd0) begin errors++; $display("FAIL reset_count got %0d want 0", instr_count); end
        tick();
        checks++; if (running !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL idle_hold running %b phase %0d want 0 0", running, phase); end
    endtask

    task automatic test_run();
        do_reset();
        run = 1'b1;
        tick();
        checks++; if (running !== 1'b1 || phase !== 3'd0) begin errors++; $display("FAIL run_start running %b phase %0d want 1 0", running, phase); end
        for (int i = 1; i < 8; i++) begin
            halt_req = (i == 3);  // ignored away from phase 4
            tick();
            checks++; if (phase !== 3'(i) || halted !== 1'b0) begin errors++; $display("FAIL run_phase got %0d halted %b want %0d 0", phase, halted, i); end
        end
        halt_req = 1'b0;
        tick();
        checks++; if (phase !== 3'd0 || instr_count !== 8'd1 || running !== 1'b1) begin errors++; $display("FAIL run_wrap phase %0d count %0d running %b want 0 1 1", phase, instr_count, running); end
        tick();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL run_second got %0d want 1", phase); end
    endtask

    task automatic test_stall();
        do_reset();
        run = 1'b1;
        tick(); tick();
        rd = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (phase !== 3'd1 || running !== 1'b1) begin errors++; $display("FAIL stall_hold phase %0d running %b want 1 1", phase, running); end
        end
        mem_ready = 1'b1;
        tick();
        checks++; if (phase !== 3'd2 || running !== 1'b1) begin errors++; $display("FAIL stall_release phase %0d running %b want 2 1", phase, running); end
        rd = 1'b0; mem_ready = 1'b0;
        tick();
        checks++; if (phase !== 3'd3) begin errors++; $display("FAIL stall_resume got %0d want 3", phase); end
    endtask

    task automatic test_timeout();
        do_reset();
        run = 1'b1;
        tick(); tick(); tick();
        wr = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        checks++; if (timeout_err !== 1'b0 || running !== 1'b1 || phase !== 3'd2) begin errors++; $display("FAIL timeout_early err %b running %b phase %0d want 0 1 2", timeout_err, running, phase); end
        tick();
        checks++; if (timeout_err !== 1'b1 || running !== 1'b0 || phase !== 3'd2) begin errors++; $display("FAIL timeout_trip err %b running %b phase %0d want 1 0 2", timeout_err, running, phase); end
        mem_ready = 1'b1;
        tick(); tick();
        checks++; if (timeout_err !== 1'b1 || phase !== 3'd2) begin errors++; $display("FAIL timeout_sticky err %b phase %0d want 1 2", timeout_err, phase); end
        do_reset();
        checks++; if (timeout_err !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL timeout_clear err %b phase %0d want 0 0", timeout_err, phase); end
    endtask

    task automatic test_halt();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        halt_req = 1'b1; run = 1'b0;
        tick();
        checks++; if (halted !== 1'b1 || phase !== 3'd0 || instr_count !== 8'd1 || running !== 1'b0) begin errors++; $display("FAIL halt_take halted %b phase %0d count %0d running %b want 1 0 1 0", halted, phase, instr_count, running); end
        halt_req = 1'b0; run = 1'b1; step = 1'b1;
        tick(); step = 1'b0; tick(); tick();
        checks++; if (halted !== 1'b1 || phase !== 3'd0 || instr_count !== 8'd1) begin errors++; $display("FAIL halt_frozen halted %b phase %0d count %0d want 1 0 1", halted, phase, instr_count); end
    endtask

    task automatic test_halt_stall();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        halt_req = 1'b1; rd = 1'b1; mem_ready = 1'b0;
        tick(); tick();
        checks++; if (halted !== 1'b0 || phase !== 3'd4 || running !== 1'b1) begin errors++; $display("FAIL halt_stall_hold halted %b phase %0d running %b want 0 4 1", halted, phase, running); end
        mem_ready = 1'b1;
        tick();
        checks++; if (halted !== 1'b1 || phase !== 3'd0 || instr_count !== 8'd1) begin errors++; $display("FAIL halt_stall_take halted %b phase %0d count %0d want 1 0 1", halted, phase, instr_count); end
        halt_req = 1'b0; rd = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic test_step();
        do_reset();
        step = 1'b1;
        tick();
        step = 1'b0;
        checks++; if (running !== 1'b1 || phase !== 3'd0) begin errors++; $display("FAIL step_start running %b phase %0d want 1 0", running, phase); end
        for (int i = 1; i < 8; i++) begin
            step = (i == 3);
            tick();
            checks++; if (phase !== 3'(i)) begin errors++; $display("FAIL step_phase got %0d want %0d", phase, i); end
        end
        step = 1'b0;
        tick();
        checks++; if (running !== 1'b0 || phase !== 3'd0 || instr_count !== 8'd1) begin errors++; $display("FAIL step_end running %b phase %0d count %0d want 0 0 1", running, phase, instr_count); end
        tick();
        checks++; if (running !== 1'b0 || phase !== 3'd0) begin errors++; $display("FAIL step_no_queue running %b phase %0d want 0 0", running, phase); end
        // run and step together: run wins, so the machine keeps going past the boundary
        run = 1'b1; step = 1'b1;
        tick();
        step = 1'b0;
        for (int i = 0; i < 8; i++) tick();
        checks++; if (running !== 1'b1 || phase !== 3'd0 || instr_count !== 8'd2) begin errors++; $display("FAIL run_beats_step running %b phase %0d count %0d want 1 0 2", running, phase, instr_count); end
        tick();
        checks++; if (phase !== 3'd1) begin errors++; $display("FAIL run_beats_step_next got %0d want 1", phase); end
    endtask

    task automatic test_run_drop_wrap();
        do_reset();
        run = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        run = 1'b0;
        for (int i = 4; i < 8; i++) begin
            tick();
            checks++; if (phase !== 3'(i) || running !== 1'b1) begin errors++; $display("FAIL drop_finish phase %0d running %b want %0d 1", phase, running, i); end
        end
        tick();
        checks++; if (running !== 1'b0 || phase !== 3'd0 || instr_count !== 8'd1) begin errors++; $display("FAIL drop_idle running %b phase %0d count %0d want 0 0 1", running, phase, instr_count); end
        run = 1'b1;
        tick();
        for (int i = 0; i < 254 * 8; i++) tick();
        checks++; if (instr_count !== 8'hFF) begin errors++; $display("FAIL count_full got %0h want ff", instr_count); end
        for (int i = 0; i < 8; i++) tick();
        checks++; if (instr_count !== 8'h00 || phase !== 3'd0) begin errors++; $display("FAIL count_wrap count %0h phase %0d want 0 0", instr_count, phase); end
        run = 1'b0;
    endtask

    initial begin
        test_reset();
        test_run();
        test_stall();
        test_timeout();
        test_halt();
        test_halt_stall();
        test_step();
        test_run_drop_wrap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Generates the 3-bit `phase` that drives the instruction controller, and decides when the machine runs, stalls, steps and stops. It sits between the top-level run/debug controls, the memory, and the controller. It advances one phase per clock through the eight-phase fetch/execute cycle. It holds `phase` while a memory access waits for `mem_ready`, honours the controller's `halt` at phase 4, supports single-instruction stepping, and counts retired instructions.

## Interface
- `WAIT_LIMIT`, default 15: maximum consecutive stall cycles before the `timeout_err` trap (1..255).
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `run`  in  1  level: enable continuous execution
- `step`  in  1  one-cycle pulse: execute exactly one instruction from IDLE
- `halt_req`  in  1  controller `halt` output
- `rd`  in  1  controller memory read enable
- `wr`  in  1  controller memory write enable
- `mem_ready`  in  1  memory access complete this cycle
- `phase`  out  3  current phase 0..7 to controller
- `running`  out  1  state is RUN or STALL
- `halted`  out  1  state is HALTED
- `timeout_err`  out  1  state is ERROR
- `instr_count`  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- Reset values: state IDLE, `phase`=0, `running`=0, `halted`=0, `timeout_err`=0, `instr_count`=0, step flag=0, wait counter=0.
- States and exits:
  - IDLE: `phase` held at 0. `run`=1 moves to RUN. Otherwise `step`=1 moves to RUN and sets the step flag. When both are asserted, `run` wins and the step flag stays clear.
  - RUN: an advance condition is computed as adv = !(rd|wr) | mem_ready.
    - adv=1: `phase` increments and the wait counter clears.
    - adv=0: `phase` holds, the wait counter increments, and the state moves to STALL.
  - STALL: `phase` holds.
    - `mem_ready`=1: advance `phase`, clear the wait counter, return to RUN.
    - Otherwise the wait counter increments. When the counter reaches WAIT_LIMIT with `mem_ready` still 0, move to ERROR.
  - HALTED: `phase`=0, frozen. `run` and `step` are ignored; exit only via `rst`.
  - ERROR: `phase` frozen at the stalled value. Sticky until `rst`.
- Instruction boundary handling:
  - Advance from phase 7: `phase` becomes 0 and `instr_count` increments.
    - If the step flag is set, or `run`=0, go to IDLE and clear the step flag.
    - Otherwise stay in RUN.
  - Advance from phase 4 with `halt_req`=1: `phase` becomes 0, `instr_count` increments (HLT retires), go to HALTED.
- `halt_req` is only acted on at phase 4; at any other phase it is ignored.
- Deasserting `run` mid-instruction never truncates the instruction; the stop happens at the next 7→0 boundary.
- `step` pulses outside IDLE are ignored, not queued.
- `rst` in any state, including mid-stall or ERROR, restores all reset values on the next edge.

## Timing
- Control inputs are sampled on the clock edge, and outputs are registered.
- `run` sampled 1 in IDLE at edge N: `running`=1 and `phase`=0 after N; `phase`=1 after N+1.
- Unstalled instruction: exactly 8 cycles in RUN, phases 0..7.
- Each stalled cycle adds one cycle; `phase` never skips a value.
- ERROR timing: it is entered on the edge where the wait counter would reach WAIT_LIMIT with `mem_ready`=0. This is WAIT_LIMIT stall cycles after entering STALL.
- `instr_count` updates on the same edge as the 7→0 (or halting 4→0) `phase` change.
- Simultaneous events:
  - `halt_req` at phase 4 with `run`=0: HALTED wins over IDLE.
  - A stall at phase 4 with `halt_req`=1: the halt is taken on the edge that finally advances.

## Test plan
- Reset, then `run`=1 with `rd`=`wr`=0: `phase` steps 0..7 once per cycle, `instr_count`=1 after 8 cycles, then 0..7 again.
- At phase 1 hold `rd`=1, `mem_ready`=0 for 3 cycles, then 1: `phase` stays 1 for 4 cycles, `running`=1 throughout, then advances to 2.
- Stall with `mem_ready`=0 held for 15 cycles (WAIT_LIMIT=15): `timeout_err`=1 and `phase` frozen. A later `mem_ready`=1 has no effect; `rst` clears `timeout_err` and sets `phase`=0.
- `halt_req`=1 at phase 4: next edge gives `halted`=1, `phase`=0, `instr_count` incremented. `run` and `step` produce no change until `rst`.
- From IDLE, a one-cycle `step` pulse: exactly one 0..7 sequence, return to IDLE with `phase`=0, `instr_count`+1. A second `step` pulse given mid-instruction is ignored.
- `run` dropped at phase 3: phases 4..7 complete, then IDLE with `phase`=0. Preload `instr_count`=0xFFFF via 65535 instructions (or force); the next completion gives 0x0000.
